i2s_master: RTL and testbench

- I2S bus master for the codec interface: generates bclk and lrclk from the system clock, serializes left/right samples onto dacda, and deserializes adcda into left/right samples.
- Pairs with the existing I2S slave-side receiver/transmitter. It is used when the FPGA, not the codec, owns the audio clocks.
- Philips I2S framing: left channel while lrclk=0, MSB one bclk after each lrclk edge, data driven on bclk falling edges and sampled on bclk rising edges.

---
 rtl/i2s_master.sv | 130 +++++++++++++
 tb/tb_i2s_master.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/i2s_master.sv
// I2S bus master: owns bclk/lrclk, shifts samples out on dacda and in from adcda
// using Philips framing (left while lrclk=0, MSB one bclk after each lrclk edge).
module i2s_master #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int SLOT_WIDTH   = 32,
    parameter int BCLK_DIV     = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic [SAMPLE_WIDTH-1:0] left_in,
    input  logic [SAMPLE_WIDTH-1:0] right_in,
    output logic                    sample_req,
    output logic                    bclk,
    output logic                    lrclk,
    output logic                    dacda,
    input  logic                    adcda,
    output logic [SAMPLE_WIDTH-1:0] left_out,
    output logic [SAMPLE_WIDTH-1:0] right_out,
    output logic                    dataready
);

    localparam int FRAME = 2 * SLOT_WIDTH;
    localparam int BW    = $clog2(FRAME);
    localparam int DW    = $clog2(BCLK_DIV);

    localparam logic [BW-1:0] POS_LAST = BW'(FRAME - 1);
    localparam logic [BW-1:0] SLOT_POS = BW'(SLOT_WIDTH);
    localparam logic [BW-1:0] Q_END    = BW'(SAMPLE_WIDTH);
    localparam logic [BW-1:0] Q_LSB    = BW'(SAMPLE_WIDTH - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(BCLK_DIV - 1);

    // Position b carries the bit of slot index b-1, wrapping so b=0 is the last right bit.
    function automatic logic [BW-1:0] slot_index(input logic [BW-1:0] pos);
        return (pos == '0) ? POS_LAST : pos - 1'b1;
    endfunction

    function automatic logic in_right(input logic [BW-1:0] pos);
        return slot_index(pos) >= SLOT_POS;
    endfunction

    function automatic logic [BW-1:0] bit_index(input logic [BW-1:0] pos);
        logic [BW-1:0] p;
        p = slot_index(pos);
        return (p >= SLOT_POS) ? p - SLOT_POS : p;
    endfunction

    // Shifting past the sample width yields the zero padding of the slot tail.
    function automatic logic tx_bit(input logic [BW-1:0]           pos,
                                    input logic [SAMPLE_WIDTH-1:0] l,
                                    input logic [SAMPLE_WIDTH-1:0] r);
        logic [SAMPLE_WIDTH-1:0] s;
        s = in_right(pos) ? r : l;
        s = s << bit_index(pos);
        return s[SAMPLE_WIDTH-1];
    endfunction

    logic [DW-1:0]           div_cnt;
    logic [BW-1:0]           frame_pos;
    logic [BW-1:0]           next_pos;
    logic [BW-1:0]           rx_q;
    logic                    rx_right;
    logic                    started;
    logic [SAMPLE_WIDTH-1:0] tx_left;
    logic [SAMPLE_WIDTH-1:0] tx_right;
    logic [SAMPLE_WIDTH-2:0] rx_shift;
    logic [SAMPLE_WIDTH-1:0] rx_word;
    logic                    adcda_m;
    logic                    adcda_s;

    assign next_pos = (frame_pos == POS_LAST) ? '0 : frame_pos + 1'b1;
    assign rx_q     = bit_index(frame_pos);
    assign rx_right = in_right(frame_pos);
    assign rx_word  = {rx_shift, adcda_s};

    always_ff @(posedge clk) begin
        adcda_m <= adcda;
        adcda_s <= adcda_m;
    end

    always_ff @(posedge clk) begin
        sample_req <= 1'b0;
        dataready  <= 1'b0;
        if (reset || !enable) begin
            div_cnt   <= '0;
            bclk      <= 1'b0;
            lrclk     <= 1'b0;
            dacda     <= 1'b0;
            frame_pos <= '0;
            started   <= 1'b0;
            tx_left   <= '0;
            tx_right  <= '0;
            rx_shift  <= '0;
            if (reset) begin
                left_out  <= '0;
                right_out <= '0;
            end
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            bclk    <= ~bclk;
            if (bclk) begin
                started   <= 1'b1;
                frame_pos <= next_pos;
                lrclk     <= (next_pos >= SLOT_POS);
                if (next_pos == BW'(1)) begin
                    tx_left    <= left_in;
                    tx_right   <= right_in;
                    dacda      <= tx_bit(next_pos, left_in, right_in);
                    sample_req <= 1'b1;
                end else begin
                    dacda <= tx_bit(next_pos, tx_left, tx_right);
                end
            // The rise before the first fall sits at b=0 of no real frame; skip it.
            end else if (started && rx_q < Q_END) begin
                rx_shift <= rx_word[SAMPLE_WIDTH-2:0];
                if (rx_q == Q_LSB) begin
                    if (rx_right) begin
                        right_out <= rx_word;
                        dataready <= 1'b1;
                    end else begin
                        left_out <= rx_word;
                    end
                end
            end
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_i2s_master.sv
// Loopback bench for i2s_master at 16-in-32 and 32-in-32 slot formats, checked
// cycle by cycle against a frame-position model derived from the I2S framing rules.
module tb_i2s_master;

    localparam int DIV   = 4;
    localparam int SLOT  = 32;
    localparam int FRAME = 2 * SLOT;
    localparam int FCLK  = FRAME * 2 * DIV;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable16 = 1'b0;
    logic        enable32 = 1'b0;
    logic [15:0] left16 = 16'hA5C3;
    logic [15:0] right16 = 16'h1234;
    logic [31:0] left32 = 32'h80000001;
    logic [31:0] right32 = 32'h7FFFFFFE;

    logic        sample_req16, bclk16, lrclk16, dacda16, dataready16;
    logic [15:0] left_out16, right_out16;
    logic        sample_req32, bclk32, lrclk32, dacda32, dataready32;
    logic [31:0] left_out32, right_out32;

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          act[2];
    int          last_req[2];
    int          nreq[2] = '{0, 0};
    int          used16 = 0;
    int          used32 = 0;
    logic [31:0] lat_l[2], lat_r[2], exp_lo[2], exp_ro[2];
    logic        rst_q = 1'b1;
    logic        en16_q = 1'b0;
    logic        en32_q = 1'b0;

    always #5 clk = ~clk;

    i2s_master #(.SAMPLE_WIDTH(16), .SLOT_WIDTH(SLOT), .BCLK_DIV(DIV)) dut16 (
        .clk(clk), .reset(reset), .enable(enable16),
        .left_in(left16), .right_in(right16), .sample_req(sample_req16),
        .bclk(bclk16), .lrclk(lrclk16), .dacda(dacda16), .adcda(dacda16),
        .left_out(left_out16), .right_out(right_out16), .dataready(dataready16)
    );

    i2s_master #(.SAMPLE_WIDTH(32), .SLOT_WIDTH(SLOT), .BCLK_DIV(DIV)) dut32 (
        .clk(clk), .reset(reset), .enable(enable32),
        .left_in(left32), .right_in(right32), .sample_req(sample_req32),
        .bclk(bclk32), .lrclk(lrclk32), .dacda(dacda32), .adcda(dacda32),
        .left_out(left_out32), .right_out(right_out32), .dataready(dataready32)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Serial bit carried at frame position pos for the pair (l, r).
    function automatic logic frame_bit(input int pos, input logic [31:0] l,
                                       input logic [31:0] r, input int sw);
        int p, q;
        logic [31:0] s;
        p = (pos + FRAME - 1) % FRAME;
        s = (p >= SLOT) ? r : l;
        q = p % SLOT;
        if (q >= sw) return 1'b0;
        return s[sw-1-q];
    endfunction

    // One clk of the model: a counts active clk edges since idle; every rule follows from it.
    task automatic mon_step(input int id, input int sw, input logic rst, input logic en,
                            input logic [31:0] lin, input logic [31:0] rin,
                            input logic [4:0] pins, input logic [31:0] lo, input logic [31:0] ro);
        int a, nf, pos, p, q;
        logic ereq, edac, edrdy;
        string pfx;
        pfx = (id == 0) ? "sw16" : "sw32";
        if (rst) begin
            act[id] = 0;
            lat_l[id] = '0;
            lat_r[id] = '0;
            exp_lo[id] = '0;
            exp_ro[id] = '0;
        end else if (!en) begin
            act[id] = 0;
        end else begin
            act[id] = act[id] + 1;
        end
        a = act[id];
        if (a == 0) last_req[id] = -1;
        nf = a / (2 * DIV);
        pos = nf % FRAME;
        ereq = (a > 0) && (a % (2 * DIV) == 0) && (pos == 1);
        if (ereq) begin
            lat_l[id] = lin;
            lat_r[id] = rin;
            nreq[id]++;
        end
        edac = (nf == 0) ? 1'b0 : frame_bit(pos, lat_l[id], lat_r[id], sw);
        edrdy = 1'b0;
        if (nf > 0 && a % (2 * DIV) == DIV) begin
            p = (pos + FRAME - 1) % FRAME;
            q = p % SLOT;
            if (q == sw - 1) begin
                if (p >= SLOT) begin
                    exp_ro[id] = lat_r[id];
                    edrdy = 1'b1;
                end else begin
                    exp_lo[id] = lat_l[id];
                end
                check_val({pfx, "_left_out"}, lo, exp_lo[id]);
                check_val({pfx, "_right_out"}, ro, exp_ro[id]);
            end
        end
        if (a == 0) begin
            check_val({pfx, "_idle_left_out"}, lo, exp_lo[id]);
            check_val({pfx, "_idle_right_out"}, ro, exp_ro[id]);
        end
        check_val({pfx, "_pins_bclk_lr_dac_req_rdy"}, pins,
                  {((a / DIV) % 2 == 1), (pos >= SLOT), edac, ereq, edrdy});
        if (pins[1]) begin
            if (last_req[id] >= 0) check_val({pfx, "_req_spacing"}, cyc - last_req[id], FCLK);
            last_req[id] = cyc;
        end
    endtask

    task automatic wait_req(input int id, input int budget);
        int start, n;
        start = nreq[id];
        n = 0;
        while (nreq[id] == start && n < budget) begin
            @(posedge clk);
            n++;
        end
        #2;
        check_val("sample_req_wait", nreq[id] != start, 1);
    endtask

    always @(posedge clk) begin
        rst_q  <= reset;
        en16_q <= enable16;
        en32_q <= enable32;
    end

    always @(negedge clk) begin
        cyc++;
        mon_step(0, 16, rst_q, en16_q, {16'h0, left16}, {16'h0, right16},
                 {bclk16, lrclk16, dacda16, sample_req16, dataready16},
                 {16'h0, left_out16}, {16'h0, right_out16});
        mon_step(1, 32, rst_q, en32_q, left32, right32,
                 {bclk32, lrclk32, dacda32, sample_req32, dataready32},
                 left_out32, right_out32);
    end

    // New input pairs are presented right after each latch.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (nreq[0] != used16) begin
                used16 = nreq[0];
                if (used16 == 1) begin
                    left16  = 16'h0001;
                    right16 = 16'h8000;
                end else begin
                    left16  = 16'($urandom);
                    right16 = 16'($urandom);
                end
            end
            if (nreq[1] != used32) begin
                used32  = nreq[1];
                left32  = $urandom;
                right32 = $urandom;
            end
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #2;
        reset    = 1'b0;
        enable16 = 1'b1;
        enable32 = 1'b1;
        repeat (4) wait_req(0, FCLK + 64);

        // Abort the 16-bit bus in the middle of the right slot (b=40).
        wait_req(0, FCLK + 64);
        repeat (318) @(posedge clk);
        #2 enable16 = 1'b0;
        repeat (12) @(posedge clk);
        #2 enable16 = 1'b1;
        repeat (3) wait_req(0, FCLK + 64);

        // One-cycle reset pulse at b=40.
        wait_req(0, FCLK + 64);
        repeat (318) @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        #2 reset = 1'b0;
        repeat (3) wait_req(0, FCLK + 64);
        repeat (20) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
